// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream, imem write port and status bundle for imem_loader
interface imem_loader_if #(
    parameter int ADDR_W = 11
);
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    modport master (
        output start, in_data, in_valid,
        input  in_ready, we, waddr, wdata, cpu_hold, done, err, words_loaded
    );

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, we, waddr, wdata, cpu_hold, done, err, words_loaded
    );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads a length-prefixed, XOR-checked byte frame into imem as big-endian words
module imem_loader #(
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 2048
) (
    input  logic               clk,
    input  logic               rstn,
    imem_loader_if.slave       bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_t;

    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    state_t            state;
    logic [15:0]       len;
    logic [23:0]       word;
    logic [1:0]        byte_cnt;
    logic [7:0]        checksum;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    logic              in_ready;
    logic              hs;
    logic [15:0]       len_next;
    logic [31:0]       word_next;
    logic [15:0]       wl_inc;

    assign in_ready  = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                       (state == S_DATA)   || (state == S_CSUM);
    assign hs        = in_ready && bus.in_valid;
    assign len_next  = {len[15:8], bus.in_data};
    assign word_next = {word, bus.in_data};
    assign wl_inc    = 16'(words_loaded) + 16'd1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= S_IDLE;
            len          <= '0;
            word         <= '0;
            byte_cnt     <= '0;
            checksum     <= '0;
            we           <= 1'b0;
            waddr        <= '0;
            wdata        <= '0;
            cpu_hold     <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
        end else begin
            we   <= 1'b0;
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (bus.start) begin
                        state        <= S_LEN_HI;
                        cpu_hold     <= 1'b1;
                        err          <= 1'b0;
                        words_loaded <= '0;
                        checksum     <= '0;
                        byte_cnt     <= '0;
                        waddr        <= '0;
                    end
                end
                S_LEN_HI: begin
                    if (hs) begin
                        len[15:8] <= bus.in_data;
                        state     <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (hs) begin
                        len[7:0] <= bus.in_data;
                        if (len_next == 16'd0 || len_next > DEPTH_W) begin
                            state    <= S_ERR;
                            err      <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (hs) begin
                        word     <= word_next[23:0];
                        checksum <= checksum ^ bus.in_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        // Fourth byte completes the word; the write strobe follows one cycle later.
                        if (byte_cnt == 2'd3) begin
                            we    <= 1'b1;
                            wdata <= word_next;
                            waddr <= words_loaded[ADDR_W-1:0];
                            state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    words_loaded <= words_loaded + 1'b1;
                    state        <= (wl_inc == len) ? S_CSUM : S_DATA;
                end
                S_CSUM: begin
                    if (hs) begin
                        cpu_hold <= 1'b0;
                        if (bus.in_data == checksum) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.we           = we;
    assign bus.waddr        = waddr;
    assign bus.wdata        = wdata;
    assign bus.cpu_hold     = cpu_hold;
    assign bus.done         = done;
    assign bus.err          = err;
    assign bus.words_loaded = words_loaded;
endmodule
